ball_collision_resolver: RTL and testbench

Parametrised N-ball collision resolver for the billiard table engine. It replaces the fixed three-ball velocity/direction update. Once per frame it takes a snapshot of every ball's position, speed and direction, then scans every ball pair in a fixed order. For each overlapping pair it exchanges speeds and sets separating directions, with a per-pair cooldown that stops balls sticking together. It sits between the position integrator (which supplies positions and state) and the VGA renderer/physics loop (which consumes the updated state on `done`).

---
 rtl/ball_collision_resolver.sv | 187 ++++++++++++++++++
 tb/tb_ball_collision_resolver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_resolver.sv
// N-ball collision resolver: snapshots ball state per frame, walks every pair in fixed order,
// swaps speeds and sets separating directions for overlapping pairs, with per-pair cooldown.
module ball_collision_resolver #(
    parameter int N_BALL      = 3,
    parameter int POS_W       = 10,
    parameter int V_W         = 2,
    parameter int BALL_R      = 8,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_BALL*POS_W-1:0] x_in,
    input  logic [N_BALL*POS_W-1:0] y_in,
    input  logic [N_BALL*V_W-1:0]   vx_in,
    input  logic [N_BALL*V_W-1:0]   vy_in,
    input  logic [N_BALL-1:0]       dx_in,
    input  logic [N_BALL-1:0]       dy_in,
    output logic [N_BALL*V_W-1:0]   vx_out,
    output logic [N_BALL*V_W-1:0]   vy_out,
    output logic [N_BALL-1:0]       dx_out,
    output logic [N_BALL-1:0]       dy_out,
    output logic [N_BALL-1:0]       hit_out,
    output logic                    busy,
    output logic                    done
);

    localparam int P      = N_BALL * (N_BALL - 1) / 2;
    localparam int IDX_W  = $clog2(N_BALL);
    localparam int PAIR_W = (P > 1) ? $clog2(P) : 1;
    localparam int CNT_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int D2_W   = 2 * POS_W + 1;

    localparam logic [D2_W-1:0]   THRESH    = D2_W'(4 * BALL_R * BALL_R);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BALL - 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(P - 1);
    localparam logic [CNT_W-1:0]  HOLD      = CNT_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY, DONE} state_t;

    state_t state, state_nxt;

    logic [POS_W-1:0]  wx  [N_BALL];
    logic [POS_W-1:0]  wy  [N_BALL];
    logic [V_W-1:0]    wvx [N_BALL];
    logic [V_W-1:0]    wvy [N_BALL];
    logic [N_BALL-1:0] wdx, wdy, hit;
    logic [CNT_W-1:0]  cool [P];

    logic [IDX_W-1:0]  idx_i, idx_j;
    logic [PAIR_W-1:0] pair;
    logic [D2_W-1:0]   d2_q;
    logic              xflag_q, yflag_q;

    logic [POS_W-1:0]  xi, xj, yi, yj, adx, ady;
    logic [D2_W-1:0]   d2;
    logic              xflag, yflag, i_right, i_below;

    // Pair geometry from the working positions of the current pair
    always_comb begin
        xi      = wx[idx_i];
        xj      = wx[idx_j];
        yi      = wy[idx_i];
        yj      = wy[idx_j];
        adx     = (xi >= xj) ? (xi - xj) : (xj - xi);
        ady     = (yi >= yj) ? (yi - yj) : (yj - yi);
        d2      = D2_W'(adx) * D2_W'(adx) + D2_W'(ady) * D2_W'(ady);
        xflag   = {adx, 1'b0} >= {1'b0, ady};
        yflag   = {ady, 1'b0} >= {1'b0, adx};
        i_right = xi > xj;
        i_below = yi > yj;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // DONE dwells two cycles: publish with the done pulse, then leave with busy/done falling together
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    state_nxt = APPLY;
            APPLY:   state_nxt = (pair == LAST_PAIR) ? DONE : SCAN;
            DONE:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_BALL; k++) begin
                wx[k]  <= '0;
                wy[k]  <= '0;
                wvx[k] <= '0;
                wvy[k] <= '0;
            end
            for (int p = 0; p < P; p++) cool[p] <= '0;
            wdx     <= '0;
            wdy     <= '0;
            hit     <= '0;
            idx_i   <= '0;
            idx_j   <= '0;
            pair    <= '0;
            d2_q    <= '0;
            xflag_q <= 1'b0;
            yflag_q <= 1'b0;
            vx_out  <= '0;
            vy_out  <= '0;
            dx_out  <= '0;
            dy_out  <= '0;
            hit_out <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_BALL; k++) begin
                            wx[k]  <= x_in[k*POS_W +: POS_W];
                            wy[k]  <= y_in[k*POS_W +: POS_W];
                            wvx[k] <= vx_in[k*V_W +: V_W];
                            wvy[k] <= vy_in[k*V_W +: V_W];
                        end
                        wdx   <= dx_in;
                        wdy   <= dy_in;
                        hit   <= '0;
                        idx_i <= '0;
                        idx_j <= IDX_W'(1);
                        pair  <= '0;
                    end
                end
                SCAN: begin
                    d2_q    <= d2;
                    xflag_q <= xflag;
                    yflag_q <= yflag;
                end
                APPLY: begin
                    if (cool[pair] != '0) begin
                        cool[pair] <= cool[pair] - CNT_W'(1);
                    end else if (d2_q <= THRESH) begin
                        wvx[idx_i] <= wvx[idx_j];
                        wvx[idx_j] <= wvx[idx_i];
                        wvy[idx_i] <= wvy[idx_j];
                        wvy[idx_j] <= wvy[idx_i];
                        if (xflag_q) begin
                            wdx[idx_i] <= i_right;
                            wdx[idx_j] <= !i_right;
                        end
                        if (yflag_q) begin
                            wdy[idx_i] <= i_below;
                            wdy[idx_j] <= !i_below;
                        end
                        cool[pair] <= HOLD;
                        hit[idx_i] <= 1'b1;
                        hit[idx_j] <= 1'b1;
                    end
                    pair <= pair + PAIR_W'(1);
                    if (idx_j == LAST_IDX) begin
                        idx_i <= idx_i + IDX_W'(1);
                        idx_j <= idx_i + IDX_W'(2);
                    end else begin
                        idx_j <= idx_j + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (!done) begin
                        for (int k = 0; k < N_BALL; k++) begin
                            vx_out[k*V_W +: V_W] <= wvx[k];
                            vy_out[k*V_W +: V_W] <= wvy[k];
                        end
                        dx_out  <= wdx;
                        dy_out  <= wdy;
                        hit_out <= hit;
                        done    <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_resolver.sv
// Directed self-checking bench for ball_collision_resolver at N_BALL=3, HOLD_FRAMES=4.
module tb_ball_collision_resolver;

    localparam int N  = 3;
    localparam int PW = 10;
    localparam int VW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [N*PW-1:0] x_in, y_in;
    logic [N*VW-1:0] vx_in, vy_in;
    logic [N-1:0]    dx_in, dy_in;
    logic [N*VW-1:0] vx_out, vy_out;
    logic [N-1:0]    dx_out, dy_out, hit_out;
    logic            busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    ball_collision_resolver #(
        .N_BALL(N), .POS_W(PW), .V_W(VW), .BALL_R(8), .HOLD_FRAMES(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
        .dx_in(dx_in), .dy_in(dy_in),
        .vx_out(vx_out), .vy_out(vy_out), .dx_out(dx_out), .dy_out(dy_out),
        .hit_out(hit_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*PW-1:0] x, y;
        logic [N*VW-1:0] vx, vy;
        logic [N-1:0]    dx, dy;
        logic [N*VW-1:0] evx, evy;
        logic [N-1:0]    edx, edy, ehit;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [N*PW-1:0] p3(int a, int b, int c);
        return {PW'(c), PW'(b), PW'(a)};
    endfunction

    function automatic logic [N*VW-1:0] v3(int a, int b, int c);
        return {VW'(c), VW'(b), VW'(a)};
    endfunction

    function automatic logic [N-1:0] b3(bit a, bit b, bit c);
        return {c, b, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drives one frame; lat counts edges from the start-sampling edge (inclusive) to done
    task automatic applyStimulus(input vec_t v, input bit extra_start, output int lat);
        x_in  = v.x;  y_in  = v.y;
        vx_in = v.vx; vy_in = v.vy;
        dx_in = v.dx; dy_in = v.dy;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (extra_start) start = (lat == 3);
        end
        start = 1'b0;
    endtask

    task automatic checkVector(input string tag, input vec_t v, input int lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_vx"},  32'(vx_out),  32'(v.evx));
        checkOutput({tag, "_vy"},  32'(vy_out),  32'(v.evy));
        checkOutput({tag, "_dx"},  32'(dx_out),  32'(v.edx));
        checkOutput({tag, "_dy"},  32'(dy_out),  32'(v.edy));
        checkOutput({tag, "_hit"}, 32'(hit_out), 32'(v.ehit));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_fall"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   lat;
        int   done_seen;
        vec_t nohit;

        // head-on, diagonal, threshold hit/miss, reversed order, three-ball chain, vertical
        vecs[0] = '{p3(100,115,400), p3(100,100,300), v3(1,3,2), v3(2,0,1), b3(1,0,1), b3(1,0,0),
                    v3(3,1,2), v3(0,2,1), b3(0,1,1), b3(1,0,0), 3'b011};
        vecs[1] = '{p3(100,111,400), p3(100,111,300), v3(1,3,2), v3(2,0,1), b3(1,0,1), b3(1,0,0),
                    v3(3,1,2), v3(0,2,1), b3(0,1,1), b3(0,1,0), 3'b011};
        vecs[2] = '{p3(100,116,400), p3(100,100,300), v3(1,3,2), v3(2,0,1), b3(1,0,1), b3(1,0,0),
                    v3(3,1,2), v3(0,2,1), b3(0,1,1), b3(1,0,0), 3'b011};
        vecs[3] = '{p3(100,117,400), p3(100,100,300), v3(1,3,2), v3(2,0,1), b3(1,0,1), b3(1,0,0),
                    v3(1,3,2), v3(2,0,1), b3(1,0,1), b3(1,0,0), 3'b000};
        vecs[4] = '{p3(115,100,400), p3(100,100,300), v3(1,3,2), v3(2,0,1), b3(0,1,1), b3(1,0,0),
                    v3(3,1,2), v3(0,2,1), b3(1,0,1), b3(1,0,0), 3'b011};
        vecs[5] = '{p3(100,110,120), p3(100,100,100), v3(1,2,3), v3(0,0,0), b3(0,1,0), b3(0,0,0),
                    v3(2,3,1), v3(0,0,0), b3(0,0,1), b3(0,0,0), 3'b111};
        vecs[6] = '{p3(200,500,200), p3(200,50,210), v3(2,1,0), v3(1,1,3), b3(1,1,0), b3(1,0,0),
                    v3(0,1,2), v3(3,1,1), b3(1,1,0), b3(0,0,1), 3'b101};

        // reset with random inputs and start held high
        x_in  = N*PW'($urandom); y_in  = N*PW'($urandom);
        vx_in = N*VW'($urandom); vy_in = N*VW'($urandom);
        dx_in = N'($urandom);    dy_in = N'($urandom);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_vx",   32'(vx_out),  32'd0);
        checkOutput("rst_vy",   32'(vy_out),  32'd0);
        checkOutput("rst_dx",   32'(dx_out),  32'd0);
        checkOutput("rst_dy",   32'(dy_out),  32'd0);
        checkOutput("rst_hit",  32'(hit_out), 32'd0);
        checkOutput("rst_busy", 32'(busy),    32'd0);
        checkOutput("rst_done", 32'(done),    32'd0);
        start = 1'b0;
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v], 1'b0, lat);
            checkVector($sformatf("vec%0d", v), vecs[v], lat);
        end

        // cooldown: same overlapping snapshot for six frames, hits only on frames 1 and 6
        nohit = vecs[0];
        nohit.evx = vecs[0].vx; nohit.evy = vecs[0].vy;
        nohit.edx = vecs[0].dx; nohit.edy = vecs[0].dy;
        nohit.ehit = 3'b000;
        doReset();
        for (int f = 1; f <= 6; f++) begin
            applyStimulus(vecs[0], 1'b0, lat);
            checkVector($sformatf("cool_f%0d", f), (f == 1 || f == 6) ? vecs[0] : nohit, lat);
        end

        // start pulsed while busy is ignored and does not queue a frame
        doReset();
        applyStimulus(vecs[5], 1'b1, lat);
        checkVector("extra_start", vecs[5], lat);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("extra_start_idle", 32'(busy), 32'd0);

        // reset at the fourth edge of a scan aborts the frame and clears everything
        doReset();
        applyStimulus(vecs[0], 1'b0, lat);
        checkVector("pre_abort", vecs[0], lat);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("abort_busy", 32'(busy),    32'd0);
        checkOutput("abort_done", 32'(done),    32'd0);
        checkOutput("abort_vx",   32'(vx_out),  32'd0);
        checkOutput("abort_dx",   32'(dx_out),  32'd0);
        checkOutput("abort_hit",  32'(hit_out), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        applyStimulus(vecs[0], 1'b0, lat);
        checkVector("post_abort", vecs[0], lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
